// File: rtl/router_fifo_if.sv
// Bus between the synchronizer/client side and one router_fifo instance.
// The master drives the write/read requests and the write data. The slave,
// which is the FIFO, returns read data and its status flags.
interface router_fifo_if #(
    parameter int DWIDTH = 8
);
    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DWIDTH-1:0] data_in;
    logic [DWIDTH-1:0] data_out;
    logic              full;
    logic              empty;
    logic              rd_busy;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, rd_busy
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, rd_busy
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination packet buffer of the router.
// Each word holds the header flag (lfd) above the data byte. When a header
// word is read, a packet counter is loaded from the header. rd_busy stays
// high until the parity byte of that packet has been read out.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int DWIDTH = 8
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           soft_reset,
    router_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DWIDTH:0]   mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [6:0]        pkt_cnt;
    logic [DWIDTH-1:0] data_out_q;

    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              rd_accept;
    logic [DWIDTH:0]   rd_word;
    logic [6:0]        header_cnt;

    // Status decode from the registered pointers; the MSB acts as the wrap bit.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        wr_accept  = bus.write_enb && !full;
        rd_accept  = bus.read_enb && !empty;
        rd_word    = mem[rd_ptr[AW-1:0]];
        header_cnt = {1'b0, rd_word[7:2]} + 7'd1;
    end

    // Storage array: the hard reset clears it, but soft reset leaves the contents in place.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!soft_reset && wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // Pointer update: both pointers wrap modulo 2*DEPTH, and a flush returns them to zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Read data register and packet counter. A header loads the remaining length (payload + parity);
    // each later byte counts down, and the counter saturates at zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out_q <= '0;
            pkt_cnt    <= '0;
        end else if (soft_reset) begin
            data_out_q <= '0;
            pkt_cnt    <= '0;
        end else if (rd_accept) begin
            data_out_q <= rd_word[DWIDTH-1:0];
            if (rd_word[DWIDTH]) begin
                pkt_cnt <= header_cnt;
            end else if (pkt_cnt != 7'd0) begin
                pkt_cnt <= pkt_cnt - 7'd1;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.rd_busy  = (pkt_cnt != 7'd0);
endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo. The reference model is a queue of
// {lfd, byte} entries plus a count of packet bytes still to be read.
module tb_router_fifo;
    localparam int DEPTH  = 16;
    localparam int DWIDTH = 8;

    logic clock;
    logic resetn;
    logic soft_reset;

    router_fifo_if #(.DWIDTH(DWIDTH)) bus ();

    router_fifo #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    int vectors;
    int miscompares;

    logic [8:0] mq[$];
    logic [7:0] m_dout;
    int         m_remaining;

    // Free-running clock with a 10-time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic modelReset();
        mq.delete();
        m_dout      = 8'h00;
        m_remaining = 0;
    endtask

    task automatic checkOutput(input string tag);
        logic       exp_full;
        logic       exp_empty;
        logic       exp_busy;
        exp_full  = (mq.size() == DEPTH);
        exp_empty = (mq.size() == 0);
        exp_busy  = (m_remaining > 0);
        vectors++;
        assert (bus.data_out === m_dout) else begin
            miscompares++;
            $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, bus.data_out, m_dout);
        end
        vectors++;
        assert (bus.full === exp_full) else begin
            miscompares++;
            $error("[TB] FAIL %s full observed=%b expected=%b", tag, bus.full, exp_full);
        end
        vectors++;
        assert (bus.empty === exp_empty) else begin
            miscompares++;
            $error("[TB] FAIL %s empty observed=%b expected=%b", tag, bus.empty, exp_empty);
        end
        vectors++;
        assert (bus.rd_busy === exp_busy) else begin
            miscompares++;
            $error("[TB] FAIL %s rd_busy observed=%b expected=%b", tag, bus.rd_busy, exp_busy);
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge and checks 1 unit later.
    task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                                 input logic [7:0] din, input logic srst, input string tag);
        bit         was_full;
        bit         was_empty;
        logic [8:0] word;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        soft_reset    = srst;
        @(posedge clock);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (srst) begin
            modelReset();
        end else begin
            if (re && !was_empty) begin
                word   = mq.pop_front();
                m_dout = word[7:0];
                if (word[8])
                    m_remaining = int'(word[7:2]) + 1;
                else if (m_remaining > 0)
                    m_remaining = m_remaining - 1;
            end
            if (we && !was_full) begin
                mq.push_back({lfd, din});
            end
        end
        #1;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        soft_reset    = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] payload[4];
        int         to_write;
        vectors       = 0;
        miscompares   = 0;
        resetn        = 1'b0;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        modelReset();

        // Reset under a clock pulse
        @(posedge clock);
        #1 checkOutput("reset clk");
        resetn = 1'b1;

        // Async reset mid-cycle after some traffic
        applyStimulus(1, 0, 1, 8'h5A, 0, "pre-ar wr");
        applyStimulus(1, 0, 0, 8'h66, 0, "pre-ar wr2");
        applyStimulus(0, 1, 0, 8'h00, 0, "pre-ar rd");
        #2 resetn = 1'b0;
        modelReset();
        #1 checkOutput("async reset");
        @(posedge clock);
        #1 checkOutput("async held");
        resetn = 1'b1;

        // Packet round trip
        $display("[TB] packet round trip");
        applyStimulus(1, 0, 1, 8'h0D, 0, "rt hdr");
        payload = '{8'h11, 8'h22, 8'h33, 8'h3F};
        foreach (payload[i]) applyStimulus(1, 0, 0, payload[i], 0, "rt wr");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h00, 0, "rt rd");

        // Fill, overflow attempt, drain, then wrap
        $display("[TB] fill and wrap");
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(i), 0, "fill wr");
        applyStimulus(1, 0, 0, 8'hAA, 0, "overflow wr");
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'h00, 0, "drain rd");
        applyStimulus(0, 1, 0, 8'h00, 0, "underflow rd");
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 8'(8'h40 + i), 0, "wrap wr");
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'h00, 0, "wrap rd");

        // Simultaneous read and write at the full and empty boundaries
        $display("[TB] simultaneous access");
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(8'h80 + i), 0, "sim fill");
        applyStimulus(1, 1, 0, 8'h77, 0, "sim full rw");
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 8'h00, 0, "sim drain");
        applyStimulus(1, 1, 0, 8'hC3, 0, "sim empty rw");
        applyStimulus(0, 1, 0, 8'h00, 0, "sim rd back");

        // Soft reset mid-packet
        $display("[TB] soft reset");
        applyStimulus(1, 0, 1, 8'h28, 0, "sr hdr");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(8'h10 + i), 0, "sr wr");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 0, "sr rd");
        applyStimulus(1, 0, 0, 8'h99, 1, "sr pulse");
        applyStimulus(0, 1, 0, 8'h00, 0, "sr after");

        // Maximum packet length streamed through while refilling
        $display("[TB] maximum length packet");
        applyStimulus(1, 0, 1, 8'hFC, 0, "max hdr");
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 8'($urandom), 0, "max wr");
        to_write = 64 - 7;
        while (to_write > 0) begin
            applyStimulus(1, 1, 0, 8'($urandom), 0, "max rw");
            to_write--;
        end
        while (mq.size() > 0) applyStimulus(0, 1, 0, 8'h00, 0, "max rd");
        applyStimulus(0, 1, 0, 8'h00, 0, "max idle");

        // Randomized traffic with occasional headers and flushes
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), 8'($urandom),
                          ($urandom_range(0, 49) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination packet buffer of the router: three instances sit directly downstream of the synchronizer, one per output port. Each stores header, payload and parity bytes written on the shared input bus under its own one-hot write enable, and returns them to the destination client on `read_enb`. Each instance reports `full`/`empty` back to the synchronizer, which uses them for flow control and for the valid-out/timeout logic. A `soft_reset` from the synchronizer's 30-cycle timeout flushes the buffer.

## Interface
- `DEPTH`, 16: number of storage words; must be a power of 2.
- `DWIDTH`, 8: data byte width; each stored word is DWIDTH+1 bits (lfd flag + byte).
- `clock`  in  1  single clock; all state is updated on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `soft_reset`  in  1  synchronous flush, one-cycle pulse from the synchronizer.
- `write_enb`  in  1  write request; this instance's bit of the synchronizer's `write_enb`.
- `read_enb`  in  1  read request from the destination client.
- `lfd_state`  in  1  high when `data_in` is a packet header (load-first-data).
- `data_in`  in  DWIDTH  byte to store.
- `data_out`  out  DWIDTH  registered read data.
- `full`  out  1  no free words.
- `empty`  out  1  no stored words.
- `rd_busy`  out  1  high while the remainder of a packet is still being read out.

## Operation
- Storage: DEPTH x (DWIDTH+1) array. Bit DWIDTH of each word holds the `lfd_state` value sampled at the write.
- Pointers: `wr_ptr` and `rd_ptr`, each log2(DEPTH)+1 bits. The low bits address the array; the MSB is the wrap bit.
  - `empty` is high when the two pointers are equal.
  - `full` is high when the low bits are equal and the MSBs differ.
- Write accept: `write_enb && !full`. Stores {`lfd_state`, `data_in`} at `wr_ptr` and increments `wr_ptr` modulo 2·DEPTH.
- Read accept: `read_enb && !empty`. Loads `data_out` with the byte field at `rd_ptr` and increments `rd_ptr`.
- Packet counter `pkt_cnt`, 7 bits. It is updated only on an accepted read:
  - Word read with lfd bit = 1: `pkt_cnt` <= byte[7:2] + 1. This is payload length plus parity, range 1..64, zero-extended before the add.
  - Word read with lfd bit = 0 and `pkt_cnt` != 0: `pkt_cnt` decrements by 1.
  - Word read with lfd bit = 0 and `pkt_cnt` = 0: `pkt_cnt` holds at 0; no underflow.
  - `rd_busy` = (`pkt_cnt` != 0).
- `data_out` holds its value when no read is accepted.
- Priority, highest first: `resetn` low, then `soft_reset`, then write/read.
  - `soft_reset`: `wr_ptr`, `rd_ptr`, `pkt_cnt` and `data_out` go to 0. Array contents are left as they are. Any write or read in the same cycle is discarded.
  - Asynchronous reset: all pointers, `pkt_cnt`, `data_out` and every array word go to 0 immediately, independent of `clock`.
- Simultaneous read and write:
  - Both are evaluated against the pre-edge `full`/`empty`.
  - When full, the read is accepted and the write is dropped.
  - When empty, the write is accepted and the read is ignored; there is no fall-through.
  - Otherwise both are accepted and the occupancy is unchanged.
- Writes while full and reads while empty are silently ignored; pointers do not move.

## Timing
- Reset values: `data_out` = 0, `full` = 0, `empty` = 1, `rd_busy` = 0.
- `full` and `empty` are combinational decodes of the registered pointers, so they change immediately after the edge that moves a pointer.
- Write latency: a word accepted at edge N clears `empty` after edge N and can be read at edge N+1.
- Read latency: `data_out` is valid after the edge at which the read is accepted, i.e. one cycle after `read_enb` is sampled.
- `rd_busy` rises after the edge that reads a header. It falls after the edge that reads the parity byte: for payload length L, that is L+1 reads after the header.
- `soft_reset` takes effect at the edge where it is sampled high. `empty` = 1 and `rd_busy` = 0 from that edge on.
- Asynchronous reset asserted mid-cycle forces every output to its reset value before the next edge. Deassertion is synchronized externally.

## Test plan
- Reset: hold `resetn` low, pulse `clock` -> `empty` = 1, `full` = 0, `data_out` = 0x00, `rd_busy` = 0. Assert `resetn` low between edges -> outputs return to these values without a clock edge.
- Packet round trip:
  - Stimulus: write 0x0D with `lfd_state` = 1 (length 3, address 1), then 0x11, 0x22, 0x33, parity 0x3F; then read 5 times.
  - Response: `data_out` = 0x0D, 0x11, 0x22, 0x33, 0x3F. `rd_busy` is high from the first read through the fourth read and low after the fifth read. `empty` = 1 after the fifth read.
- Fill and wrap:
  - Write 0x00..0x0F -> `full` = 1 after the 16th write. A 17th write of 0xAA is ignored.
  - Read 16 times -> 0x00..0x0F in order, then `empty` = 1.
  - Write 8 more words and read 8 more words -> pointers wrap and order is preserved.
- Simultaneous read and write:
  - When full: the read returns the oldest word, the write is dropped, and `full` = 0 after the edge.
  - When empty: the write is stored, `data_out` is unchanged, and `empty` = 0 after the edge.
- Soft reset mid-packet: after a header with length 10 and two payload reads, pulse `soft_reset` together with `write_enb` -> `empty` = 1, `rd_busy` = 0, `data_out` = 0x00, and the write is not stored.
- Maximum length: a header with length 63 (0xFC) -> `rd_busy` stays high for exactly 64 reads after the header without counter overflow. The FIFO is refilled concurrently with reads so the full 65-byte packet passes through.
